// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: three-channel 8-bit PWM for the SB_RGBA_DRV inputs with double-buffered duties.
// Define RGB_PWM_FADE_EN to make active duties step by one per period toward the written value.
module rgb_pwm_ctrl #(
    parameter int unsigned PRESC_DIV = 23,
    parameter bit          RESET_EN  = 1'b0
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       red_pwm,
    output logic       green_pwm,
    output logic       blue_pwm,
    output logic       period_start
);
    localparam logic [1:0]  ADDR_CTRL = 2'd3;
    localparam logic [15:0] PRESC_TC  = 16'(PRESC_DIV);

    logic [15:0] presc_cnt_reg;
    logic [7:0]  pwm_cnt_reg;
    logic        enable_reg;
    logic        upd_pend_reg;
    logic        period_start_reg;

    logic        tick;
    logic        boundary;
    logic        ctrl_wr;
    logic [2:0]  duty_wr;
    logic [2:0]  chan_eq;
    logic [2:0]  pwm_vec;
    logic [7:0]  pend_vec [3];

    assign tick     = enable_reg && (presc_cnt_reg == PRESC_TC);
    assign boundary = tick && (pwm_cnt_reg == 8'hFF);
    assign ctrl_wr  = wr_en && (wr_addr == ADDR_CTRL);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [7:0] pend_reg;
            logic [7:0] act_reg;
            logic [7:0] act_next;
            logic       pwm_reg;

            assign duty_wr[gi] = wr_en && (wr_addr == 2'(gi));

`ifdef RGB_PWM_FADE_EN
            // Fade: one LSB per period toward the programmed duty.
            always_comb begin
                act_next = act_reg;
                if (act_reg < pend_reg) begin
                    act_next = act_reg + 8'd1;
                end else if (act_reg > pend_reg) begin
                    act_next = act_reg - 8'd1;
                end
            end
`else
            assign act_next = pend_reg;
`endif

            // Channel has settled once the boundary update lands on the pending value.
            assign chan_eq[gi]  = (act_next == pend_reg);
            assign pend_vec[gi] = pend_reg;
            assign pwm_vec[gi]  = pwm_reg;

            always_ff @(posedge HCLK) begin
                if (!HRESETn) begin
                    pend_reg <= 8'h00;
                    act_reg  <= 8'h00;
                    pwm_reg  <= 1'b0;
                end else begin
                    if (duty_wr[gi]) begin
                        pend_reg <= wr_data;
                    end
                    // While disabled the active duty follows the buffer so re-enable starts clean.
                    if (!enable_reg) begin
                        act_reg <= pend_reg;
                    end else if (boundary) begin
                        act_reg <= act_next;
                    end
                    pwm_reg <= enable_reg && (pwm_cnt_reg < act_reg);
                end
            end
        end
    endgenerate

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            presc_cnt_reg    <= 16'h0000;
            pwm_cnt_reg      <= 8'h00;
            enable_reg       <= RESET_EN;
            upd_pend_reg     <= 1'b0;
            period_start_reg <= 1'b0;
        end else begin
            if (!enable_reg) begin
                presc_cnt_reg <= 16'h0000;
                pwm_cnt_reg   <= 8'h00;
            end else begin
                presc_cnt_reg <= tick ? 16'h0000 : presc_cnt_reg + 16'd1;
                if (tick) begin
                    pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
                end
            end

            period_start_reg <= boundary;

            if (ctrl_wr) begin
                enable_reg <= wr_data[0];
            end

            // A duty write always wins over a coincident clear.
            if (|duty_wr) begin
                upd_pend_reg <= 1'b1;
            end else if (!enable_reg || (boundary && (&chan_eq))) begin
                upd_pend_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            2'd0:    rd_data = pend_vec[0];
            2'd1:    rd_data = pend_vec[1];
            2'd2:    rd_data = pend_vec[2];
            default: rd_data = {6'b000000, upd_pend_reg, enable_reg};
        endcase
    end

    assign red_pwm      = pwm_vec[0];
    assign green_pwm    = pwm_vec[1];
    assign blue_pwm     = pwm_vec[2];
    assign period_start = period_start_reg;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb_rgb_pwm_ctrl: directed scenarios plus randomized register traffic for rgb_pwm_ctrl,
// compared every cycle against an arithmetic model of period position, duties and status.
module tb_rgb_pwm_ctrl;
    localparam int P   = 2;
    localparam int PER = 256 * (P + 1);

    logic       HCLK    = 1'b0;
    logic       HRESETn = 1'b0;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rd_data;
    logic       red_pwm;
    logic       green_pwm;
    logic       blue_pwm;
    logic       period_start;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_r, cnt_g, cnt_b, cnt_ps;

    // Reference model: period position is derived from cycles elapsed since enable.
    bit m_en;
    bit m_upd;
    bit m_ps;
    bit m_pwm [3];
    int m_pend [3];
    int m_act [3];
    int m_phase;

    always #5 HCLK = ~HCLK;

    rgb_pwm_ctrl #(.PRESC_DIV(P), .RESET_EN(1'b0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .red_pwm(red_pwm), .green_pwm(green_pwm), .blue_pwm(blue_pwm),
        .period_start(period_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [1:0] a);
        if (a == 2'd3) return {6'b000000, m_upd, m_en};
        return 8'(m_pend[a]);
    endfunction

    task automatic model_clock(input bit rstn, input bit we, input int wa, input int wd);
        int  cnt;
        bit  tick;
        bit  bnd;
        bit  all_eq;
        int  nxt [3];
        if (!rstn) begin
            m_en = 1'b0; m_upd = 1'b0; m_ps = 1'b0; m_phase = 0;
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 0; m_act[i] = 0; m_pwm[i] = 1'b0;
            end
            return;
        end
        cnt  = (m_phase / (P + 1)) % 256;
        tick = m_en && ((m_phase % (P + 1)) == P);
        bnd  = tick && (cnt == 255);
        m_ps = bnd;
        all_eq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_pwm[i] = m_en && (cnt < m_act[i]);
            nxt[i] = m_act[i];
            if (!m_en) begin
                nxt[i] = m_pend[i];
            end else if (bnd) begin
`ifdef RGB_PWM_FADE_EN
                nxt[i] = m_act[i] + int'(m_pend[i] > m_act[i]) - int'(m_pend[i] < m_act[i]);
`else
                nxt[i] = m_pend[i];
`endif
            end
            if (nxt[i] != m_pend[i]) all_eq = 1'b0;
        end
        if (we && wa < 3) m_upd = 1'b1;
        else if (!m_en || (bnd && all_eq)) m_upd = 1'b0;
        m_phase = m_en ? m_phase + 1 : 0;
        for (int i = 0; i < 3; i++) m_act[i] = nxt[i];
        if (we && wa < 3) m_pend[wa] = wd & 255;
        if (we && wa == 3) m_en = wd[0];
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
    task automatic cycle(input bit we, input int wa, input int wd, input bit rstn);
        wr_en   = we;
        wr_addr = 2'(wa);
        wr_data = 8'(wd);
        HRESETn = rstn;
        rd_addr = 2'($urandom_range(0, 3));
        @(posedge HCLK);
        model_clock(rstn, we, wa, wd);
        @(negedge HCLK);
        if (we) $display("[%0t] wr addr=%0d data=0x%02h", $time, wa, wd[7:0]);
        if (!rstn) $display("[%0t] reset pulse", $time);
        check("red_pwm", red_pwm, m_pwm[0]);
        check("green_pwm", green_pwm, m_pwm[1]);
        check("blue_pwm", blue_pwm, m_pwm[2]);
        check("period_start", period_start, m_ps);
        check("rd_data", rd_data, exp_rd(rd_addr));
        cnt_r  += int'(red_pwm);
        cnt_g  += int'(green_pwm);
        cnt_b  += int'(blue_pwm);
        cnt_ps += int'(period_start);
        wr_en = 1'b0;
    endtask

    task automatic check_read(input string tag, input int addr, input int exp);
        rd_addr = 2'(addr);
        #1;
        check(tag, rd_data, exp);
    endtask

    // Stops just before the rising edge on which the period wraps.
    task automatic to_boundary();
        int guard = 0;
        while (!(m_en && (m_phase % PER == PER - 1)) && guard < 2 * PER) begin
            cycle(1'b0, 0, 0, 1'b1);
            guard++;
        end
        check("boundary_reached", int'(guard < 2 * PER), 1);
    endtask

    // One full period of samples after a wrap; optional write and status read at index pidx.
    task automatic measure(input int pidx, input bit we, input int wa, input int wd);
        cnt_r = 0; cnt_g = 0; cnt_b = 0; cnt_ps = 0;
        for (int k = 0; k < PER; k++) begin
            cycle(we && (k == pidx), wa, wd, 1'b1);
            if (k == pidx) check_read("ctrl_pending", 3, 'h03);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1);
    end

    initial begin
        int run;
        int r, wa, wd;
        @(negedge HCLK);
        cycle(1'b0, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0);
        for (int a = 0; a < 4; a++) check_read("reset_rd", a, 'h00);
        check("reset_red", red_pwm, 1'b0);
        check("reset_ps", period_start, 1'b0);

`ifdef RGB_PWM_FADE_EN
        cycle(1'b1, 3, 'h01, 1'b1);
        cycle(1'b1, 0, 'h03, 1'b1);
        to_boundary();
        cycle(1'b0, 0, 0, 1'b1);
        measure(-1, 1'b0, 0, 0);
        check("fade_red_p1", cnt_r, 1 * (P + 1));
        check_read("fade_ctrl_p1", 3, 'h03);
        measure(-1, 1'b0, 0, 0);
        check("fade_red_p2", cnt_r, 2 * (P + 1));
        check_read("fade_ctrl_p2", 3, 'h01);
        measure(-1, 1'b0, 0, 0);
        check("fade_red_p3", cnt_r, 3 * (P + 1));
        measure(-1, 1'b0, 0, 0);
        check("fade_red_p4", cnt_r, 3 * (P + 1));
`else
        cycle(1'b1, 3, 'h01, 1'b1);
        cycle(1'b1, 0, 'h40, 1'b1);
        cycle(1'b1, 1, 'h00, 1'b1);
        cycle(1'b1, 2, 'hFF, 1'b1);
        to_boundary();
        cycle(1'b0, 0, 0, 1'b1);
        measure(-1, 1'b0, 0, 0);
        check("red_64", cnt_r, 64 * (P + 1));
        check("green_0", cnt_g, 0);
        check("blue_255", cnt_b, 255 * (P + 1));
        check("ps_per_period", cnt_ps, 1);

        measure(PER / 2, 1'b1, 0, 'h80);
        check("red_keeps_64", cnt_r, 64 * (P + 1));
        check_read("ctrl_after_bnd", 3, 'h01);
        measure(-1, 1'b0, 0, 0);
        check("red_128", cnt_r, 128 * (P + 1));

        to_boundary();
        cycle(1'b1, 0, 'h10, 1'b1);
        check_read("ctrl_bnd_write", 3, 'h03);
        measure(PER / 2, 1'b0, 0, 0);
        check("red_old_at_bnd", cnt_r, 128 * (P + 1));
        check_read("ctrl_after_bnd2", 3, 'h01);
        measure(-1, 1'b0, 0, 0);
        check("red_16", cnt_r, 16 * (P + 1));
`endif

        cycle(1'b1, 0, 'h80, 1'b1);
        to_boundary();
        cycle(1'b0, 0, 0, 1'b1);
        repeat (50) cycle(1'b0, 0, 0, 1'b1);
        cycle(1'b1, 3, 'h00, 1'b1);
        cycle(1'b0, 0, 0, 1'b1);
        check("red_off_disabled", red_pwm, 1'b0);
        repeat (5) cycle(1'b0, 0, 0, 1'b1);
        check_read("ctrl_disabled", 3, 'h00);
        cycle(1'b1, 3, 'h01, 1'b1);
        check("red_at_enable", red_pwm, 1'b0);
        cycle(1'b0, 0, 0, 1'b1);
        check("red_pulse_start", red_pwm, 1'b1);
        run = 0;
        while (red_pwm && run < PER) begin
            run++;
            cycle(1'b0, 0, 0, 1'b1);
        end
        check("red_first_pulse", run, 128 * (P + 1));

        cycle(1'b1, 1, 'h20, 1'b1);
        cycle(1'b1, 2, 'h30, 1'b1);
        repeat (300) cycle(1'b0, 0, 0, 1'b1);
        cycle(1'b0, 0, 0, 1'b0);
        check("rst_red", red_pwm, 1'b0);
        check("rst_green", green_pwm, 1'b0);
        check("rst_blue", blue_pwm, 1'b0);
        check("rst_ps", period_start, 1'b0);
        for (int a = 0; a < 4; a++) check_read("rst_rd", a, 'h00);
        measure(-1, 1'b0, 0, 0);
        check("rst_no_ps", cnt_ps, 0);
        check("rst_no_red", cnt_r, 0);

        for (int n = 0; n < 12000; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                cycle(1'b0, 0, 0, 1'b0);
            end else if (r < 60) begin
                wa = int'($urandom_range(0, 3));
                if (wa == 3) begin
                    wd = (int'($urandom_range(0, 255)) & 32'hFE) | int'($urandom_range(0, 7) != 0);
                end else if ($urandom_range(0, 3) == 0) begin
                    wd = ($urandom_range(0, 1) != 0) ? 255 : 0;
                end else begin
                    wd = int'($urandom_range(0, 255));
                end
                cycle(1'b1, wa, wd, 1'b1);
            end else begin
                cycle(1'b0, 0, 0, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
